fifo_word_packer: RTL and testbench

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

---
 rtl/fifo_word_packer_pkg.sv | 11 +
 rtl/fifo_word_packer_if.sv | 27 ++
 rtl/fifo_word_packer.sv | 110 +++++++++++
 tb/tb_fifo_word_packer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_word_packer_pkg.sv
// Shared defaults and FSM state encoding for the FIFO word packer.
package fifo_pack_pkg;
    localparam int DIN_W_DEF = 8;
    localparam int PACK_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/fifo_word_packer_if.sv
// Signal bundle between the packer, its upstream sync FIFO and the word sink.
interface fifo_word_packer_if
    import fifo_pack_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEF,
    parameter int PACK  = PACK_DEF
) ();
    logic                  fifo_empty;
    logic [DIN_W-1:0]      fifo_data;
    logic                  fifo_rd_en;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIN_W*PACK-1:0] out_data;
    logic [PACK-1:0]       out_keep;
    logic                  out_last;

    modport master (
        input  fifo_empty, fifo_data, flush, out_ready,
        output fifo_rd_en, out_valid, out_data, out_keep, out_last
    );

    modport slave (
        output fifo_empty, fifo_data, flush, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops bytes from a sync FIFO and packs PACK of them into one output word,
// with flush emitting a partially filled word.
//
// state | meaning
// IDLE  | no lanes filled, no read in flight
// FILL  | 1..PACK-1 lanes filled, or a read in flight
// HOLD  | word presented on out_*, waiting for out_ready
module fifo_word_packer
    import fifo_pack_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEF,
    parameter int PACK  = PACK_DEF
) (
    input  logic               clk,
    input  logic               rst,
    fifo_word_packer_if.master bus
);
    localparam int CNT_W = $clog2(PACK + 1);
    localparam int CW1   = CNT_W + 1;
    localparam logic [CNT_W:0] PACK_N = CW1'(PACK);

    state_t                state, state_n;
    logic [CNT_W-1:0]      fill_cnt, fill_cnt_n;
    logic                  rd_pending;
    logic                  rd_en;
    logic                  flush_hit;
    logic [CNT_W:0]        n_filled;
    logic [DIN_W-1:0]      lane   [PACK];
    logic [DIN_W-1:0]      lane_n [PACK];
    logic [PACK-1:0]       keep, keep_n;
    logic                  last, last_n;
    logic [DIN_W*PACK-1:0] data_w;

    assign flush_hit = bus.flush && (state == FILL);
    assign n_filled  = {1'b0, fill_cnt} + {{CNT_W{1'b0}}, rd_pending};

    // Reads stop while a flush is being taken so the flushed word is exactly
    // the lanes already filled plus any capture still in flight.
    assign rd_en = rst && !bus.fifo_empty && (state != HOLD)
                   && (n_filled < PACK_N) && !flush_hit;

    always_comb begin
        state_n    = state;
        fill_cnt_n = fill_cnt;
        keep_n     = keep;
        last_n     = last;
        lane_n     = lane;
        case (state)
            IDLE: begin
                if (rd_en) state_n = FILL;
            end
            FILL: begin
                if (rd_pending) begin
                    for (int i = 0; i < PACK; i++) begin
                        if (fill_cnt == CNT_W'(i)) lane_n[i] = bus.fifo_data;
                    end
                    fill_cnt_n = fill_cnt + 1'b1;
                end
                if (n_filled == PACK_N) begin
                    state_n = HOLD;
                    keep_n  = '1;
                    last_n  = 1'b0;
                end else if (flush_hit) begin
                    state_n = HOLD;
                    last_n  = 1'b1;
                    for (int i = 0; i < PACK; i++) keep_n[i] = (n_filled > CW1'(i));
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_n    = IDLE;
                    fill_cnt_n = '0;
                    keep_n     = '0;
                    last_n     = 1'b0;
                    for (int i = 0; i < PACK; i++) lane_n[i] = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            rd_pending <= 1'b0;
            keep       <= '0;
            last       <= 1'b0;
            for (int i = 0; i < PACK; i++) lane[i] <= '0;
        end else begin
            state      <= state_n;
            fill_cnt   <= fill_cnt_n;
            rd_pending <= rd_en;
            keep       <= keep_n;
            last       <= last_n;
            for (int i = 0; i < PACK; i++) lane[i] <= lane_n[i];
        end
    end

    always_comb begin
        data_w = '0;
        for (int i = 0; i < PACK; i++) data_w[i*DIN_W +: DIN_W] = lane[i];
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = (state == HOLD);
    assign bus.out_data   = data_w;
    assign bus.out_keep   = keep;
    assign bus.out_last   = last;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: models the upstream FIFO and checks packed words
// against byte-stream chunking.
module tb_fifo_word_packer;
    import fifo_pack_pkg::*;

    localparam int DW = DIN_W_DEF;
    localparam int PK = PACK_DEF;
    localparam int WW = DW * PK;

    typedef struct packed {
        logic [WW-1:0] data;
        logic [PK-1:0] keep;
        logic          last;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_word_packer_if #(.DIN_W(DW), .PACK(PK)) bus ();
    fifo_word_packer #(.DIN_W(DW), .PACK(PK)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] fq[$];
    word_t         got[$];
    int            rd_cyc[$];
    int            cyc, rd_bad, rd_hold, hold_err, underflow, valid_seen;
    logic          prev_stall;
    word_t         prev_w;
    int            n_checks, n_fail;

    // Expected word for a chunk of bytes: lane 0 in the LSBs, one keep bit per
    // byte, last set only for a short (flushed) chunk.
    function automatic word_t model_word(input logic [DW-1:0] b[$]);
        word_t w;
        w = '0;
        for (int i = 0; i < b.size(); i++) w.data[i*DW +: DW] = b[i];
        w.keep = PK'((1 << b.size()) - 1);
        w.last = (b.size() < PK);
        return w;
    endfunction

    task automatic clear_obs();
        got.delete();
        rd_cyc.delete();
        rd_bad = 0; rd_hold = 0; hold_err = 0; underflow = 0; valid_seen = 0;
    endtask

    task automatic push_seq(input int first, input int stp, input int n);
        for (int i = 0; i < n; i++) fq.push_back(DW'(first + i * stp));
    endtask

    // One clock cycle: sample at negedge+2, then play the FIFO at posedge+1.
    task automatic step();
        word_t w;
        logic  rd;
        #2;
        w  = {bus.out_data, bus.out_keep, bus.out_last};
        rd = bus.fifo_rd_en;
        if (prev_stall && (!bus.out_valid || w != prev_w)) hold_err++;
        if (bus.out_valid) valid_seen++;
        if (bus.out_valid && bus.out_ready) got.push_back(w);
        if (rd) begin
            rd_cyc.push_back(cyc);
            if (bus.fifo_empty) rd_bad++;
            if (bus.out_valid) rd_hold++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_w     = w;
        @(posedge clk);
        #1;
        if (rd && fq.size() > 0) bus.fifo_data = fq.pop_front();
        else begin
            if (rd) underflow++;
            bus.fifo_data = DW'($urandom);
        end
        bus.fifo_empty = (fq.size() == 0);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (got.size() >= n);
    endtask

    task automatic test_reset();
        clear_obs();
        rst = 1'b0; bus.out_ready = 1'b1; bus.flush = 1'b0;
        push_seq(8'h11, 8'h11, 4);
        repeat (3) step();
        #1;
        n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_checks++; if ({bus.out_data, bus.out_keep, bus.out_last} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h/%h/%b want 0", bus.out_data, bus.out_keep, bus.out_last); end
        n_checks++; if (rd_cyc.size() != 0) begin n_fail++; $display("FAIL reset_no_reads: got %0d reads want 0", rd_cyc.size()); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL first_rd_after_reset: got %b want 1", bus.fifo_rd_en); end
    endtask

    task automatic test_basic_pack();
        bit ok; word_t w, e;
        clear_obs();
        run_until(1, 30, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got %0d words want 1", got.size()); end
        w = (got.size() > 0) ? got[0] : '0;
        e = '{32'h44332211, 4'hF, 1'b0};
        n_checks++; if (w !== e) begin n_fail++; $display("FAIL basic_word: got %h want %h", w, e); end
        n_checks++; if (rd_cyc.size() != 4) begin n_fail++; $display("FAIL basic_rd_count: got %0d want 4", rd_cyc.size()); end
        if (rd_cyc.size() == 4) begin
            n_checks++; if (rd_cyc[3] - rd_cyc[0] != 3) begin n_fail++; $display("FAIL basic_back_to_back: got span %0d want 3", rd_cyc[3] - rd_cyc[0]); end
        end
        repeat (2) step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bit ok; word_t w, e;
        clear_obs();
        bus.out_ready = 1'b0;
        push_seq(8'h01, 1, 8);
        repeat (12) begin
            step();
            bus.flush = bus.out_valid;
        end
        e = '{32'h04030201, 4'hF, 1'b0};
        w = {bus.out_data, bus.out_keep, bus.out_last};
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (w !== e) begin n_fail++; $display("FAIL bp_held_word: got %h want %h", w, e); end
        n_checks++; if (rd_cyc.size() != 4) begin n_fail++; $display("FAIL bp_rd_count: got %0d want 4", rd_cyc.size()); end
        n_checks++; if (rd_hold != 0) begin n_fail++; $display("FAIL bp_rd_in_hold: got %0d want 0", rd_hold); end
        n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", hold_err); end
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        run_until(2, 30, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got %0d words want 2", got.size()); end
        w = (got.size() > 0) ? got[0] : '0;
        n_checks++; if (w !== e) begin n_fail++; $display("FAIL bp_word0: got %h want %h", w, e); end
        e = '{32'h08070605, 4'hF, 1'b0};
        w = (got.size() > 1) ? got[1] : '0;
        n_checks++; if (w !== e) begin n_fail++; $display("FAIL bp_word1: got %h want %h", w, e); end
    endtask

    task automatic test_flush();
        bit ok; word_t w, e;
        clear_obs();
        push_seq(8'hAA, 8'h11, 2);
        repeat (8) step();
        n_checks++; if (got.size() != 0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_early_word: got %0d words valid %b want 0", got.size(), bus.out_valid); end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        run_until(1, 10, ok);
        e = '{32'h0000BBAA, 4'b0011, 1'b1};
        w = (got.size() > 0) ? got[0] : '0;
        n_checks++; if (w !== e) begin n_fail++; $display("FAIL flush_word: got %h want %h", w, e); end
    endtask

    task automatic test_flush_pending();
        bit ok; word_t w, e;
        logic [DW-1:0] chunk[$];
        clear_obs();
        push_seq(8'hC1, 1, 4);
        for (int k = 0; k < 20; k++) begin
            step();
            if (rd_cyc.size() >= 3) break;
        end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        run_until(1, 10, ok);
        chunk = {8'hC1, 8'hC2, 8'hC3};
        e = model_word(chunk);
        w = (got.size() > 0) ? got[0] : '0;
        n_checks++; if (w !== e) begin n_fail++; $display("FAIL flush_pend_word: got %h want %h", w, e); end
        n_checks++; if (rd_cyc.size() != 3) begin n_fail++; $display("FAIL flush_pend_rd_count: got %0d want 3", rd_cyc.size()); end
        repeat (6) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        run_until(2, 10, ok);
        chunk = {8'hC4};
        e = model_word(chunk);
        w = (got.size() > 1) ? got[1] : '0;
        n_checks++; if (w !== e) begin n_fail++; $display("FAIL flush_pend_leftover: got %h want %h", w, e); end
    endtask

    task automatic test_flush_on_full();
        bit ok; word_t w, e;
        clear_obs();
        push_seq(8'hD1, 1, 4);
        for (int k = 0; k < 20; k++) begin
            step();
            if (rd_cyc.size() >= 4) break;
        end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        run_until(1, 10, ok);
        repeat (5) step();
        e = '{32'hD4D3D2D1, 4'hF, 1'b0};
        w = (got.size() > 0) ? got[0] : '0;
        n_checks++; if (w !== e) begin n_fail++; $display("FAIL flush_full_word: got %h want %h", w, e); end
        n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL flush_full_count: got %0d want 1", got.size()); end
    endtask

    task automatic test_reset_mid_fill();
        bit ok; word_t w, e;
        clear_obs();
        push_seq(8'hE1, 1, 2);
        repeat (6) step();
        rst = 1'b0;
        #1;
        n_checks++; if (bus.fifo_rd_en !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got rd %b valid %b want 0", bus.fifo_rd_en, bus.out_valid); end
        n_checks++; if ({bus.out_data, bus.out_keep, bus.out_last} !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %h/%h/%b want 0", bus.out_data, bus.out_keep, bus.out_last); end
        repeat (2) step();
        rst = 1'b1;
        clear_obs();
        push_seq(8'h55, 1, 4);
        run_until(1, 30, ok);
        e = '{32'h58575655, 4'hF, 1'b0};
        w = (got.size() > 0) ? got[0] : '0;
        n_checks++; if (w !== e) begin n_fail++; $display("FAIL midrst_word: got %h want %h", w, e); end
    endtask

    task automatic test_empty();
        clear_obs();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            bus.flush = 1'($urandom_range(0, 1));
            step();
        end
        bus.flush = 1'b0;
        n_checks++; if (rd_cyc.size() != 0) begin n_fail++; $display("FAIL empty_reads: got %0d want 0", rd_cyc.size()); end
        n_checks++; if (valid_seen != 0) begin n_fail++; $display("FAIL empty_valid: got %0d cycles want 0", valid_seen); end
    endtask

    task automatic test_random();
        bit ok;
        int n, nexp, pushed;
        logic [DW-1:0] sent[$];
        logic [DW-1:0] chunk[$];
        logic [DW-1:0] b;
        word_t w, e;
        clear_obs();
        n = $urandom_range(41, 63);
        pushed = 0;
        while (pushed < n) begin
            if ($urandom_range(0, 2) != 0) begin
                b = DW'($urandom);
                fq.push_back(b);
                sent.push_back(b);
                pushed++;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.out_ready = 1'b1;
        run_until(n / PK, 300, ok);
        repeat (6) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        nexp = n / PK + ((n % PK != 0) ? 1 : 0);
        run_until(nexp, 20, ok);
        repeat (4) step();
        n_checks++; if (got.size() != nexp) begin n_fail++; $display("FAIL rand_word_count: got %0d want %0d", got.size(), nexp); end
        for (int i = 0; i < nexp; i++) begin
            chunk.delete();
            for (int j = i * PK; j < n && j < (i + 1) * PK; j++) chunk.push_back(sent[j]);
            e = model_word(chunk);
            w = (i < got.size()) ? got[i] : '0;
            n_checks++; if (w !== e) begin n_fail++; $display("FAIL rand_word[%0d]: got %h want %h", i, w, e); end
        end
        n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL rand_stable: got %0d changes want 0", hold_err); end
        n_checks++; if (rd_bad + underflow != 0) begin n_fail++; $display("FAIL rand_underflow: got %0d want 0", rd_bad + underflow); end
        n_checks++; if (rd_hold != 0) begin n_fail++; $display("FAIL rand_rd_in_hold: got %0d want 0", rd_hold); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        prev_stall = 1'b0; prev_w = '0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_pack();
        test_backpressure();
        test_flush();
        test_flush_pending();
        test_flush_on_full();
        test_reset_mid_fill();
        test_empty();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
